xy_input_unit: RTL

//  Input port of the mesh switch: buffers incoming flits in a FIFO and presents the head

---
 rtl/xy_input_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/xy_input_unit.sv
// Mesh switch input port: a small flit FIFO whose head address feeds the XY
// router, plus a wormhole controller that pins the router's port choice for
// the whole packet and streams flits to the crossbar with valid/ready.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no packet open; waiting for a HEAD/HEAD_TAIL at FIFO head
// ST_ACTIVE | route latched; forwarding flits until TAIL/HEAD_TAIL leaves

module xy_input_unit #(
  parameter int BUFFER_DEPTH_W    = 2,
  parameter int FLIT_ID_W         = 2,
  parameter int FLIT_DATA_W       = 8,
  parameter int PACKET_ADDR_COL_W = 4,
  parameter int PACKET_ADDR_ROW_W = 4,
  parameter int OUTPUT_N_W        = 3
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [FLIT_ID_W+FLIT_DATA_W-1:0]  data_i,
  input  logic                              wr_en_i,
  output logic                              full_o,
  output logic [PACKET_ADDR_COL_W-1:0]      col_addr_o,
  output logic [PACKET_ADDR_ROW_W-1:0]      row_addr_o,
  input  logic [OUTPUT_N_W-1:0]             out_chan_sel_i,
  output logic [OUTPUT_N_W-1:0]             out_chan_sel_o,
  output logic [FLIT_ID_W+FLIT_DATA_W-1:0]  data_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic                              err_o
);

  localparam int DEPTH  = 1 << BUFFER_DEPTH_W;
  localparam int FLIT_W = FLIT_ID_W + FLIT_DATA_W;
  localparam int AW     = BUFFER_DEPTH_W;

  localparam logic [FLIT_ID_W-1:0] ID_BODY      = FLIT_ID_W'(2'b00);
  localparam logic [FLIT_ID_W-1:0] ID_TAIL      = FLIT_ID_W'(2'b01);
  localparam logic [FLIT_ID_W-1:0] ID_HEAD      = FLIT_ID_W'(2'b10);
  localparam logic [FLIT_ID_W-1:0] ID_HEAD_TAIL = FLIT_ID_W'(2'b11);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [FLIT_W-1:0]     mem [DEPTH];
  logic [AW:0]           wr_ptr_q;
  logic [AW:0]           rd_ptr_q;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic [FLIT_W-1:0]     head;
  logic [FLIT_ID_W-1:0]  head_id;
  logic                  head_opens;
  logic                  head_closes;

  state_t                state_q;
  state_t                state_d;
  logic [OUTPUT_N_W-1:0] route_q;
  logic [OUTPUT_N_W-1:0] route_d;
  logic                  err_q;
  logic                  err_d;
  logic                  valid;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A write while full is dropped even if the head leaves on the same edge.
  assign push = wr_en_i && !full;

  assign head        = mem[rd_ptr_q[AW-1:0]];
  assign head_id     = head[FLIT_W-1 -: FLIT_ID_W];
  assign head_opens  = (head_id == ID_HEAD) || (head_id == ID_HEAD_TAIL);
  assign head_closes = (head_id == ID_TAIL) || (head_id == ID_HEAD_TAIL);

  // Flit storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  // FIFO pointers, wrapping modulo twice the depth.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Controller state, held route and the registered error pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      route_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      err_q   <= err_d;
    end
  end

  // Next-state, route capture, pop and valid decisions.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    err_d   = 1'b0;
    pop     = 1'b0;
    valid   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          if (head_opens) begin
            route_d = out_chan_sel_i;
            state_d = ST_ACTIVE;
          end else begin
            // Orphan BODY/TAIL with no open packet: discard and flag it.
            pop   = 1'b1;
            err_d = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        valid = !empty;
        if (valid && ready_i) begin
          pop = 1'b1;
          if (head_closes) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign full_o         = full;
  assign col_addr_o     = head[PACKET_ADDR_COL_W-1:0];
  assign row_addr_o     = head[PACKET_ADDR_COL_W+PACKET_ADDR_ROW_W-1:PACKET_ADDR_COL_W];
  assign out_chan_sel_o = route_q;
  assign data_o         = head;
  assign valid_o        = valid;
  assign err_o          = err_q;

endmodule
